stream_demux2: RTL and testbench
================================

STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port s_data, input, DATA_WIDTH bits: input payload.
REQ-005 SHALL have port s_sel, input, 1 bit: route select (1 routes to output a, 0 to output b), qualified by s_valid.
REQ-006 SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-007 SHALL have port s_ready, output, 1 bit: input beat accepted when s_valid and s_ready are both high.
REQ-008 SHALL have ports a_data and b_data, output, DATA_WIDTH bits each: registered output payloads.
REQ-009 SHALL have ports a_valid and b_valid, output, 1 bit each: output beat valid.
REQ-010 SHALL have ports a_ready and b_ready, input, 1 bit each: downstream accept.

Function
REQ-011 SHALL hold one output register stage per channel, each consisting of a data register and a valid flag.
REQ-012 SHALL drive s_ready as a combinational function of the selected channel: (~x_valid | x_ready), where x is the channel chosen by s_sel.
REQ-013 SHALL on accept, when s_sel=1, load s_data into a_data and set a_valid on the next edge; when s_sel=0 it SHALL do the same into b_data/b_valid.
REQ-014 SHALL have a latency of exactly 1 cycle from input accept to the corresponding x_valid being high.
REQ-015 SHALL clear x_valid on the edge where x_valid and x_ready are both high, unless a new beat loads the same channel on that edge.
REQ-016 SHALL, when a channel drains and reloads on the same edge, keep x_valid high and present the new data, giving one beat per cycle per channel.
REQ-017 SHALL hold x_data and x_valid stable while x_valid=1 and x_ready=0.
REQ-018 SHALL never change the unselected channel's registers because of an input beat.
REQ-019 SHALL allow a full, stalled unselected channel without blocking beats routed to the other channel.
REQ-020 SHALL preserve beat order within each channel; no ordering is guaranteed across channels.
REQ-021 SHALL not depend on s_sel or s_data when s_valid=0.
REQ-022 SHALL be correct for any DATA_WIDTH of 1 or more.

Reset
REQ-023 SHALL force a_valid=0 and b_valid=0 immediately on rst_n low, independent of clk.
REQ-024 SHALL reset a_data and b_data to all zeros.
REQ-025 SHALL discard in-flight beats on reset mid-operation; s_ready then follows REQ-012 with both valids at 0, so it is 1.
REQ-026 SHALL perform the first accept on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro STREAM_DEMUX2_CNT_EN is defined, add outputs a_cnt and b_cnt, 16 bits each, that count completed output handshakes (x_valid & x_ready) per channel.
REQ-028 SHALL, with STREAM_DEMUX2_CNT_EN defined, reset both counters to 0 and wrap them from 16'hFFFF to 16'h0000.
REQ-029 SHALL, without STREAM_DEMUX2_CNT_EN, omit the counter ports and logic entirely; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: reset, then s_valid=1, s_sel=1, s_data=32'hA5A5_0001, a_ready=1 -> a_valid=1 with a_data=32'hA5A5_0001 one cycle later; b_valid stays 0.
REQ-031 SHALL cover: a_ready=0 with a_valid=1 and a beat sent with s_sel=1 -> s_ready=0 and a_data held; raising a_ready -> the beat is accepted on the same edge the old beat drains.
REQ-032 SHALL cover: a stalled full, beat sent with s_sel=0 and s_data=32'h0000_00BB -> s_ready=1 and b_data=32'h0000_00BB next cycle.
REQ-033 SHALL cover: a_ready=1 continuously and 8 back-to-back beats with s_sel=1 -> 8 consecutive a_valid cycles with data in order and no bubbles.
REQ-034 SHALL cover: rst_n pulsed low mid-clock with both channels valid -> a_valid and b_valid fall immediately and data reads 0.
REQ-035 SHALL cover, with STREAM_DEMUX2_CNT_EN: 65537 a-channel handshakes -> a_cnt=16'h0001 and b_cnt=0.

Source files
------------

// File: rtl/stream_demux2_if.sv
// Stream demux bus: one input stream with a route select and two output streams.
// master = the side that drives the input beat and the downstream readies,
// slave  = the demux itself.
interface stream_demux2_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_sel;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_valid;
    logic                  b_ready;

    modport master (
        output s_data, s_sel, s_valid, a_ready, b_ready,
        input  s_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  s_data, s_sel, s_valid, a_ready, b_ready,
        output s_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/stream_demux2.sv
// stream_demux2: routes each input beat to channel a (s_sel=1) or b (s_sel=0).
// Each channel has a single registered output slot (data + valid). The input
// ready follows only the selected channel, so a stalled channel never blocks
// beats headed for the other one.
// Optional feature: define STREAM_DEMUX2_CNT_EN to add per-channel 16-bit
// counters (a_cnt, b_cnt) of completed output handshakes.
module stream_demux2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_demux2_if.slave       bus
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    output logic [15:0]          a_cnt,
    output logic [15:0]          b_cnt
`endif
);

    logic [DATA_WIDTH-1:0] a_data_p1;
    logic [DATA_WIDTH-1:0] b_data_p1;
    logic                  a_vld_p1;
    logic                  b_vld_p1;

    logic a_open;
    logic b_open;
    logic a_load;
    logic b_load;

    // Slot availability, input ready and per-channel load strobes.
    always_comb begin
        a_open = ~a_vld_p1 | bus.a_ready;
        b_open = ~b_vld_p1 | bus.b_ready;
        bus.s_ready = bus.s_sel ? a_open : b_open;
        a_load = bus.s_valid &  bus.s_sel & a_open;
        b_load = bus.s_valid & ~bus.s_sel & b_open;
    end

    // ---- stage p1: output slots ----

    // Valid flags: a load wins over a drain so back-to-back beats see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_p1 <= 1'b0;
            b_vld_p1 <= 1'b0;
        end else begin
            if (a_load)
                a_vld_p1 <= 1'b1;
            else if (bus.a_ready)
                a_vld_p1 <= 1'b0;
            if (b_load)
                b_vld_p1 <= 1'b1;
            else if (bus.b_ready)
                b_vld_p1 <= 1'b0;
        end
    end

    // Data registers capture only on a load into their own channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_p1 <= '0;
            b_data_p1 <= '0;
        end else begin
            if (a_load)
                a_data_p1 <= bus.s_data;
            if (b_load)
                b_data_p1 <= bus.s_data;
        end
    end

    // Drive the output side of the bus from the slot registers.
    always_comb begin
        bus.a_data  = a_data_p1;
        bus.a_valid = a_vld_p1;
        bus.b_data  = b_data_p1;
        bus.b_valid = b_vld_p1;
    end

`ifdef STREAM_DEMUX2_CNT_EN
    // Handshake counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 16'h0000;
            b_cnt <= 16'h0000;
        end else begin
            if (a_vld_p1 & bus.a_ready)
                a_cnt <= a_cnt + 16'h0001;
            if (b_vld_p1 & bus.b_ready)
                b_cnt <= b_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Testbench for stream_demux2: directed scenarios plus randomized traffic
// checked against a queue-based model of the two output slots.
module tb_stream_demux2;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    stream_demux2_if #(.DATA_WIDTH(W)) bus();

`ifdef STREAM_DEMUX2_CNT_EN
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
`endif

    stream_demux2 #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STREAM_DEMUX2_CNT_EN
        ,
        .a_cnt (a_cnt),
        .b_cnt (b_cnt)
`endif
    );

    // Reference model: each channel holds the beats accepted but not yet
    // taken downstream. A beat is accepted when its channel is empty or is
    // being drained this cycle.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    function automatic logic exp_ready();
        if (bus.s_sel) return (qa.size() == 0) || bus.a_ready;
        else           return (qb.size() == 0) || bus.b_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic         acc;
        logic [W-1:0] d;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            acc = bus.s_valid && exp_ready();
            d   = bus.s_data;
            if (qa.size() != 0 && bus.a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && bus.b_ready) void'(qb.pop_front());
            if (acc) begin
                if (bus.s_sel) qa.push_back(d);
                else           qb.push_back(d);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_sel = 1'b0; bus.s_data = '0;
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", bus.a_valid); else n_pass++;
        n_total++; if (bus.b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", bus.b_valid); else n_pass++;
        n_total++; if (bus.a_data !== 32'h0) $display("FAIL reset_a_data: got %h want 0", bus.a_data); else n_pass++;
        n_total++; if (bus.b_data !== 32'h0) $display("FAIL reset_b_data: got %h want 0", bus.b_data); else n_pass++;
        n_total++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready_b: got %b want 1", bus.s_ready); else n_pass++;
        bus.s_sel = 1'b1; #1;
        n_total++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready_a: got %b want 1", bus.s_ready); else n_pass++;
`ifdef STREAM_DEMUX2_CNT_EN
        n_total++; if (a_cnt !== 16'h0 || b_cnt !== 16'h0) $display("FAIL reset_cnt: got %h/%h want 0/0", a_cnt, b_cnt); else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // First beat right after reset release lands one cycle later on channel a.
    task automatic test_single();
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 32'hA5A5_0001;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b1) $display("FAIL single_a_valid: got %b want 1", bus.a_valid); else n_pass++;
        n_total++; if (bus.a_data !== 32'hA5A5_0001) $display("FAIL single_a_data: got %h want a5a50001", bus.a_data); else n_pass++;
        n_total++; if (bus.b_valid !== 1'b0) $display("FAIL single_b_valid: got %b want 0", bus.b_valid); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.a_valid); else n_pass++;
    endtask

    task automatic test_stall();
        bus.a_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 32'h0000_0011;
        @(posedge clk); #1;
        bus.s_data = 32'h0000_0022;
        @(negedge clk);
        n_total++; if (bus.s_ready !== 1'b0) $display("FAIL stall_s_ready: got %b want 0", bus.s_ready); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (bus.a_data !== 32'h11 || bus.a_valid !== 1'b1) $display("FAIL stall_hold: got %h/%b want 00000011/1", bus.a_data, bus.a_valid); else n_pass++;
        bus.a_ready = 1'b1; #1;
        n_total++; if (bus.s_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", bus.s_ready); else n_pass++;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.a_data !== 32'h22 || bus.a_valid !== 1'b1) $display("FAIL stall_reload: got %h/%b want 00000022/1", bus.a_data, bus.a_valid); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", bus.a_valid); else n_pass++;
    endtask

    task automatic test_other_channel();
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 32'h0000_0033;
        @(posedge clk); #1;
        bus.s_sel = 1'b0; bus.s_data = 32'h0000_00BB;
        @(negedge clk);
        n_total++; if (bus.s_ready !== 1'b1) $display("FAIL other_s_ready: got %b want 1", bus.s_ready); else n_pass++;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hBB) $display("FAIL other_b: got %h/%b want 000000bb/1", bus.b_data, bus.b_valid); else n_pass++;
        n_total++; if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h33) $display("FAIL other_a_held: got %h/%b want 00000033/1", bus.a_data, bus.a_valid); else n_pass++;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 32'hC0DE_0000;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i < 7) bus.s_data = 32'hC0DE_0000 + 32'(i + 1);
            else       bus.s_valid = 1'b0;
            @(negedge clk);
            n_total++;
            if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hC0DE_0000 + 32'(i))
                $display("FAIL b2b_beat%0d: got %h/%b want %h/1", i, bus.a_data, bus.a_valid, 32'hC0DE_0000 + 32'(i));
            else n_pass++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", bus.a_valid); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_sel   = 1'($urandom);
            bus.s_data  = $urandom;
            bus.a_ready = ($urandom_range(0, 2) != 0);
            bus.b_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n_total++; if (bus.s_ready !== exp_ready()) $display("FAIL rand_s_ready@%0d: got %b want %b", i, bus.s_ready, exp_ready()); else n_pass++;
            n_total++; if (bus.a_valid !== (qa.size() != 0)) $display("FAIL rand_a_valid@%0d: got %b want %b", i, bus.a_valid, qa.size() != 0); else n_pass++;
            n_total++; if (bus.b_valid !== (qb.size() != 0)) $display("FAIL rand_b_valid@%0d: got %b want %b", i, bus.b_valid, qb.size() != 0); else n_pass++;
            if (qa.size() != 0) begin
                n_total++; if (bus.a_data !== qa[0]) $display("FAIL rand_a_data@%0d: got %h want %h", i, bus.a_data, qa[0]); else n_pass++;
            end
            if (qb.size() != 0) begin
                n_total++; if (bus.b_data !== qb[0]) $display("FAIL rand_b_data@%0d: got %h want %h", i, bus.b_data, qb[0]); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        bus.s_valid = 1'b0; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 32'h0000_00AA;
        @(posedge clk); #1;
        bus.s_sel = 1'b0; bus.s_data = 32'h0000_0055;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) $display("FAIL areset_pre: got %b/%b want 1/1", bus.a_valid, bus.b_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) $display("FAIL areset_valid: got %b/%b want 0/0", bus.a_valid, bus.b_valid); else n_pass++;
        n_total++; if (bus.a_data !== 32'h0 || bus.b_data !== 32'h0) $display("FAIL areset_data: got %h/%h want 0/0", bus.a_data, bus.b_data); else n_pass++;
        n_total++; if (bus.s_ready !== 1'b1) $display("FAIL areset_s_ready: got %b want 1", bus.s_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef STREAM_DEMUX2_CNT_EN
        n_total++; if (a_cnt !== 16'h0 || b_cnt !== 16'h0) $display("FAIL areset_cnt: got %h/%h want 0/0", a_cnt, b_cnt); else n_pass++;
`endif
    endtask

`ifdef STREAM_DEMUX2_CNT_EN
    task automatic test_counter();
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bus.s_data = 32'(i);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (a_cnt !== 16'h0001) $display("FAIL cnt_a_wrap: got %h want 0001", a_cnt); else n_pass++;
        n_total++; if (b_cnt !== 16'h0000) $display("FAIL cnt_b: got %h want 0000", b_cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_other_channel();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef STREAM_DEMUX2_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
